accum_sched: RTL and testbench
==============================

ACCUM_SCHED -- requirements
Module: accum_sched

Interface
REQ-001 Parameter FRAME_LEN, default 1023, meaning samples per accumulation job (range 2..65535).
REQ-002 Parameter DRAIN_CYCLES, default 16, meaning zero-load cycles after last sample before acc_result is sampled (range 1..255).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req[1:0]  input  2  per-requester job request.
REQ-006 valid[1:0]  input  2  per-requester sample valid.
REQ-007 data0, data1  input  16 each  requester sample data.
REQ-008 ready[1:0]  output  2  sample accepted this cycle (only granted requester).
REQ-009 grant[1:0]  output  2  one-hot owner of the accumulator, 00 when idle.
REQ-010 acc_clear  output  1  one-cycle clear pulse to the accumulator.
REQ-011 acc_load  output  32  registered load word to the accumulator.
REQ-012 acc_result  input  32  accumulator running result.
REQ-013 res_valid  output  1  job result available; res_ready  input  1  consumer accepts.
REQ-014 res_data  output  32  captured sum; res_id  output  1  requester index; res_err  output  1  job aborted.

Function
REQ-015 FSM states IDLE, CLEAR, STREAM, DRAIN, DONE; exactly one active.
REQ-016 IDLE: if any req bit high, grant chosen round-robin (priority to requester other than last served; requester 0 after reset), next state CLEAR; otherwise stay, grant=00.
REQ-017 CLEAR: acc_clear=1 and acc_load=0 for exactly one cycle, then STREAM.
REQ-018 STREAM: ready asserted only for granted index; beat = valid&ready of granted requester.
REQ-019 Each beat: acc_load registered to {16'b0,data} next cycle; no beat: acc_load=0 (bubble adds zero).
REQ-020 Beat counter 16-bit; on the FRAME_LEN-th beat ready deasserts next cycle and state goes DRAIN.
REQ-021 req and valid of the non-granted requester ignored; grant held until DONE completes, even if granted req drops.
REQ-022 DRAIN: acc_load=0 for DRAIN_CYCLES cycles; on last drain cycle acc_result captured into res_data, then DONE.
REQ-023 DONE: res_valid=1, res_id=granted index, res_data stable until res_valid&res_ready; then round-robin pointer updated, grant=00, IDLE.
REQ-024 res_ready simultaneous with res_valid rising: transfer completes that cycle; new job may be granted no earlier than the following IDLE cycle.
REQ-025 Minimum job latency with continuous valid: 1 (CLEAR) + FRAME_LEN + DRAIN_CYCLES cycles from grant to res_valid.

Reset
REQ-026 On reset (any state, including mid-STREAM): state IDLE, grant=00, ready=00, acc_clear=0, acc_load=0, res_valid=0, res_data=0, res_id=0, res_err=0, beat counter 0, round-robin pointer favouring requester 0.
REQ-027 A job interrupted by reset produces no result; requester must re-request.

Configuration
REQ-028 Macro ACCUM_SCHED_TIMEOUT_EN: when defined, an 8-bit idle counter in STREAM counts consecutive no-beat cycles; reaching 255 aborts to DONE with res_err=1, res_data=0, skipping DRAIN.
REQ-029 Without ACCUM_SCHED_TIMEOUT_EN: no timeout logic, STREAM waits indefinitely, res_err tied 0.

Verification
REQ-030 Single job: req=01, 1023 beats of value 1 continuous -> grant=01, acc_clear pulse, res_valid 1040 cycles after grant with res_data=acc_result sample, res_id=0.
REQ-031 Contention: req=11 from reset -> requester 0 served first, requester 1 next; then both re-request -> order alternates 0,1,0,1.
REQ-032 Bubbles: valid toggled every other cycle in STREAM -> acc_load 0 on no-beat cycles, exactly FRAME_LEN nonzero-source loads, DRAIN starts after last beat.
REQ-033 Backpressure: res_ready held low 50 cycles in DONE -> res_valid, res_data, grant stable; no new acc_clear until after handshake.
REQ-034 Reset at beat 500 -> all outputs at reset values next cycle, no res_valid; fresh req restarts with acc_clear.
REQ-035 With ACCUM_SCHED_TIMEOUT_EN: valid stops after beat 10 -> res_valid with res_err=1, res_data=0 after 255 idle cycles; without macro, no result ever issued.

Source files
------------

// File: rtl/accum_sched.sv
// accum_sched: two-requester round-robin scheduler that streams fixed-length jobs into an external accumulator.
// Optional feature macro ACCUM_SCHED_TIMEOUT_EN aborts a stalled STREAM after 255 consecutive idle cycles.
module accum_sched #(
   parameter int unsigned FRAME_LEN    = 1023,
   parameter int unsigned DRAIN_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  req,
   input  logic [1:0]  valid,
   input  logic [15:0] data0,
   input  logic [15:0] data1,
   output logic [1:0]  ready,
   output logic [1:0]  grant,
   output logic        acc_clear,
   output logic [31:0] acc_load,
   input  logic [31:0] acc_result,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_id,
   output logic        res_err
);
   localparam int unsigned BEAT_W  = 16;
   localparam int unsigned DRAIN_W = 8;
   localparam int unsigned DATA_W  = 16;
   localparam logic [BEAT_W-1:0]  LAST_BEAT  = BEAT_W'(FRAME_LEN - 1);
   localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(DRAIN_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

   state_t              state;
   logic [BEAT_W-1:0]   beat_cnt;
   logic [DRAIN_W-1:0]  drain_cnt;
   logic                owner;
   logic                last_served;
   logic                next_owner;
   logic                beat;
   logic [DATA_W-1:0]   owner_data;

   // Contention goes to whoever was not served last; a lone request wins outright.
   assign next_owner = (req == 2'b11) ? ~last_served : req[1];
   assign beat       = ready[owner] & valid[owner];
   assign owner_data = owner ? data1 : data0;

`ifdef ACCUM_SCHED_TIMEOUT_EN
   localparam int unsigned IDLE_W = 8;
   logic [IDLE_W-1:0] idle_cnt;
   logic              timeout;

   assign timeout = !beat && (idle_cnt == IDLE_W'(254));

   // Consecutive no-beat cycles while streaming.
   always_ff @(posedge clk) begin
      if (reset || state != STREAM || beat) idle_cnt <= '0;
      else                                  idle_cnt <= idle_cnt + 1'b1;
   end
`else
   assign res_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         grant       <= 2'b00;
         ready       <= 2'b00;
         acc_clear   <= 1'b0;
         acc_load    <= '0;
         res_valid   <= 1'b0;
         res_data    <= '0;
         res_id      <= 1'b0;
         beat_cnt    <= '0;
         drain_cnt   <= '0;
         owner       <= 1'b0;
         last_served <= 1'b1;
`ifdef ACCUM_SCHED_TIMEOUT_EN
         res_err     <= 1'b0;
`endif
      end else begin
         acc_clear <= 1'b0;
         acc_load  <= '0;
         case (state)
            IDLE: begin
               if (req != 2'b00) begin
                  owner     <= next_owner;
                  grant     <= next_owner ? 2'b10 : 2'b01;
                  acc_clear <= 1'b1;
                  state     <= CLEAR;
               end
            end
            CLEAR: begin
               ready    <= grant;
               beat_cnt <= '0;
               state    <= STREAM;
            end
            STREAM: begin
               if (beat) begin
                  acc_load <= {16'b0, owner_data};
                  beat_cnt <= beat_cnt + 1'b1;
                  if (beat_cnt == LAST_BEAT) begin
                     ready     <= 2'b00;
                     drain_cnt <= '0;
                     state     <= DRAIN;
                  end
               end
`ifdef ACCUM_SCHED_TIMEOUT_EN
               else if (timeout) begin
                  ready     <= 2'b00;
                  res_valid <= 1'b1;
                  res_data  <= '0;
                  res_id    <= owner;
                  res_err   <= 1'b1;
                  state     <= DONE;
               end
`endif
            end
            DRAIN: begin
               drain_cnt <= drain_cnt + 1'b1;
               if (drain_cnt == LAST_DRAIN) begin
                  res_data  <= acc_result;
                  res_id    <= owner;
                  res_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (res_ready) begin
                  res_valid   <= 1'b0;
                  grant       <= 2'b00;
                  last_served <= owner;
                  state       <= IDLE;
`ifdef ACCUM_SCHED_TIMEOUT_EN
                  res_err     <= 1'b0;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_accum_sched.sv
// tb_accum_sched: job-level checks of accum_sched against a bench accumulator and a round-robin job model.
module tb_accum_sched;
   localparam int unsigned FRAME_LEN    = 1023;
   localparam int unsigned DRAIN_CYCLES = 16;

   logic        clk_tb = 1'b0;
   logic        reset;
   logic [1:0]  req;
   logic [1:0]  valid;
   logic [15:0] data0, data1;
   logic [1:0]  ready, grant;
   logic        acc_clear;
   logic [31:0] acc_load;
   logic [31:0] acc_result;
   logic        res_valid, res_ready;
   logic [31:0] res_data;
   logic        res_id, res_err;

   int n_cmp = 0;
   int n_bad = 0;
   int model_last = 1;

   typedef struct {
      logic       do_reset;
      logic [1:0] reqs;
      int         mode;
      int         bp;
      int         exp_idx;
   } vec_t;
   vec_t vecs[7];

   accum_sched #(.FRAME_LEN(FRAME_LEN), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
      .clk(clk_tb), .reset(reset), .req(req), .valid(valid),
      .data0(data0), .data1(data1), .ready(ready), .grant(grant),
      .acc_clear(acc_clear), .acc_load(acc_load), .acc_result(acc_result),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_id(res_id), .res_err(res_err)
   );

   always #5 clk_tb = ~clk_tb;

   // Bench-side accumulator the scheduler drives.
   always @(posedge clk_tb) begin
      if (reset || acc_clear) acc_result <= 32'd0;
      else                    acc_result <= acc_result + acc_load;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_tb);
      #1;
   endtask

   task automatic drive(input int g, input logic v, input logic [15:0] d);
      logic [15:0] nd;
      nd = 16'($urandom);
      valid[g]     = v;
      valid[1 - g] = 1'($urandom_range(1));
      if (g == 0) begin data0 = d;  data1 = nd; end
      else        begin data1 = d;  data0 = nd; end
   endtask

   task automatic do_reset();
      reset = 1'b1; req = 2'b00; valid = 2'b00; res_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;
      model_last = 1;
   endtask

   // One full job: grant, CLEAR, FRAME_LEN beats, drain, result, optional backpressure, handshake.
   task automatic run_job(input logic [1:0] reqs, input int mode, input int bp, input int exp_idx);
      int n, beats, cyc, bad, nz;
      logic [31:0] sum, prev_load;
      logic [1:0]  gmask;
      logic        v;
      logic [15:0] d;
      gmask = 2'(1 << exp_idx);
      req = reqs;
      n = 0;
      while (grant == 2'b00 && n < 20) begin tick(); n++; end
      chk("grant", 32'(grant), 32'(gmask));
      chk("acc_clear_pulse", 32'(acc_clear), 32'd1);
      chk("clear_load", acc_load, 32'd0);
      chk("clear_ready", 32'(ready), 32'd0);
      req[exp_idx] = 1'b0;
      tick();
      beats = 0; cyc = 0; bad = 0; nz = 0; sum = 0; prev_load = 0;
      while (beats < int'(FRAME_LEN) && cyc < 4 * int'(FRAME_LEN)) begin
         if (ready !== gmask || acc_clear !== 1'b0 || res_valid !== 1'b0 || grant !== gmask) bad++;
         if (acc_load !== prev_load) bad++;
         if (acc_load != 32'd0) nz++;
         case (mode)
            0:       v = 1'b1;
            1:       v = (cyc % 2 == 0);
            default: v = ($urandom_range(3) != 0);
         endcase
         d = 16'($urandom_range(65535, 1));
         drive(exp_idx, v, d);
         prev_load = v ? 32'(d) : 32'd0;
         if (v) begin beats++; sum += 32'(d); end
         tick();
         cyc++;
      end
      chk("stream_beats", 32'(beats), 32'(FRAME_LEN));
      chk("stream_cycles_bad", 32'(bad), 32'd0);
      bad = 0;
      for (int i = 0; i < int'(DRAIN_CYCLES); i++) begin
         if (ready !== 2'b00 || res_valid !== 1'b0 || grant !== gmask) bad++;
         if (acc_load !== prev_load) bad++;
         if (acc_load != 32'd0) nz++;
         prev_load = 32'd0;
         drive(exp_idx, 1'($urandom_range(1)), 16'($urandom));
         tick();
      end
      valid = 2'b00;
      chk("drain_bad", 32'(bad), 32'd0);
      chk("nonzero_loads", 32'(nz), 32'(FRAME_LEN));
      chk("res_valid", 32'(res_valid), 32'd1);
      chk("res_data", res_data, sum);
      chk("res_id", 32'(res_id), 32'(exp_idx));
      chk("res_err", 32'(res_err), 32'd0);
      chk("done_grant", 32'(grant), 32'(gmask));
      bad = 0;
      for (int i = 0; i < bp; i++) begin
         if (res_valid !== 1'b1 || res_data !== sum || grant !== gmask || acc_clear !== 1'b0 || ready !== 2'b00) bad++;
         tick();
      end
      chk("backpressure_hold", 32'(bad), 32'd0);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("handshake_idle", 32'({res_valid, grant, acc_clear}), 32'd0);
      model_last = exp_idx;
   endtask

   initial begin
      int n, bad, exp_idx;
      logic [1:0] reqs;
      vecs[0] = '{1'b1, 2'b01, 0, 0,  0};
      vecs[1] = '{1'b1, 2'b11, 0, 0,  0};
      vecs[2] = '{1'b0, 2'b11, 1, 50, 1};
      vecs[3] = '{1'b0, 2'b11, 2, 3,  0};
      vecs[4] = '{1'b0, 2'b11, 0, 0,  1};
      vecs[5] = '{1'b0, 2'b10, 0, 1,  1};
      vecs[6] = '{1'b0, 2'b01, 2, 2,  0};
      reset = 1'b1; req = 2'b00; valid = 2'b00; data0 = 16'd0; data1 = 16'd0; res_ready = 1'b0;
      do_reset();
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_outs", 32'({acc_clear, res_valid, res_id, res_err}), 32'd0);
      chk("rst_load", acc_load, 32'd0);
      chk("rst_res_data", res_data, 32'd0);

      for (int k = 0; k < 7; k++) begin
         if (vecs[k].do_reset) do_reset();
         run_job(vecs[k].reqs, vecs[k].mode, vecs[k].bp, vecs[k].exp_idx);
      end

      for (int k = 0; k < 6; k++) begin
         reqs = 2'($urandom_range(3, 1));
         exp_idx = (reqs == 2'b11) ? 1 - model_last : ((reqs == 2'b10) ? 1 : 0);
         run_job(reqs, 2, $urandom_range(5), exp_idx);
      end

      // Reset in the middle of a stream.
      req = 2'b01;
      n = 0;
      while (grant == 2'b00 && n < 20) begin tick(); n++; end
      chk("rst_job_grant", 32'(grant), 32'd1);
      req = 2'b00;
      tick();
      for (int i = 0; i < 500; i++) begin drive(0, 1'b1, 16'($urandom_range(65535, 1))); tick(); end
      reset = 1'b1;
      tick();
      chk("midrst_grant_ready", 32'({grant, ready}), 32'd0);
      chk("midrst_outs", 32'({acc_clear, res_valid, res_id, res_err}), 32'd0);
      chk("midrst_load", acc_load, 32'd0);
      chk("midrst_res_data", res_data, 32'd0);
      reset = 1'b0; valid = 2'b00; model_last = 1;
      bad = 0;
      for (int i = 0; i < 1100; i++) begin
         if (res_valid !== 1'b0 || grant !== 2'b00 || ready !== 2'b00) bad++;
         tick();
      end
      chk("midrst_no_result", 32'(bad), 32'd0);
      run_job(2'b11, 0, 0, 0);

      // Stall after ten beats.
      req = 2'b01;
      n = 0;
      while (grant == 2'b00 && n < 20) begin tick(); n++; end
      chk("stall_grant", 32'(grant), 32'd1);
      req = 2'b00;
      tick();
      for (int i = 0; i < 10; i++) begin drive(0, 1'b1, 16'd7); tick(); end
      n = 0;
      while (res_valid !== 1'b1 && n < 400) begin drive(0, 1'b0, 16'd7); tick(); n++; end
      valid = 2'b00;
`ifdef ACCUM_SCHED_TIMEOUT_EN
      chk("timeout_result", 32'(res_valid), 32'd1);
      chk("timeout_err", 32'(res_err), 32'd1);
      chk("timeout_data", res_data, 32'd0);
      chk("timeout_id", 32'(res_id), 32'd0);
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      chk("timeout_handshake", 32'({res_valid, res_err, grant}), 32'd0);
`else
      chk("stall_no_result", 32'(res_valid), 32'd0);
      chk("stall_err_low", 32'(res_err), 32'd0);
      do_reset();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
